// File: rtl/lbuf_wr_ctrl_if.sv
// rtl/lbuf_wr_ctrl_if.sv - source-timing and line-buffer write signals of the write controller
interface lbuf_wr_ctrl_if;
  logic       HSYNC_src;
  logic       VSYNC_src;
  logic       pix_valid;
  logic [5:0] rd_line;
  logic       rd_active;
  logic       wr_en;
  logic [8:0] wr_addr;
  logic [5:0] wr_line;
  logic       frame_start;
  logic       line_done;
  logic       overrun;
  logic [2:0] state;

  // Video source / reader side: drives timing and read position, observes writes.
  modport master (
    output HSYNC_src, VSYNC_src, pix_valid, rd_line, rd_active,
    input  wr_en, wr_addr, wr_line, frame_start, line_done, overrun, state
  );

  // Write controller side.
  modport slave (
    input  HSYNC_src, VSYNC_src, pix_valid, rd_line, rd_active,
    output wr_en, wr_addr, wr_line, frame_start, line_done, overrun, state
  );
endinterface

// File: rtl/lbuf_wr_ctrl.sv
// rtl/lbuf_wr_ctrl.sv - writes the active window of each source line into a ring of line buffers
module lbuf_wr_ctrl #(
  parameter int NUM_LINE_BUFFERS = 40,
  parameter int H_START          = 64,
  parameter int H_ACTIVE         = 384,
  parameter int V_START          = 16,
  parameter int V_ACTIVE         = 224
) (
  input logic           PCLK,
  input logic           reset,
  lbuf_wr_ctrl_if.slave bus
);

  localparam int LCW = ($clog2(V_START + 1)  > 0) ? $clog2(V_START + 1)  : 1;
  localparam int PCW = ($clog2(H_START + 1)  > 0) ? $clog2(H_START + 1)  : 1;
  localparam int ACW = ($clog2(V_ACTIVE + 1) > 0) ? $clog2(V_ACTIVE + 1) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VBLANK = 3'd1,
    HWAIT  = 3'd2,
    ACTIVE = 3'd3,
    LDONE  = 3'd4
  } state_t;

  state_t           state_q;
  logic             hs_prev_q;
  logic             vs_prev_q;
  logic [LCW-1:0]   line_cnt_q;
  logic [PCW-1:0]   pix_cnt_q;
  logic [ACW-1:0]   act_cnt_q;
  logic [8:0]       addr_cnt_q;
  logic             armed_q;
  logic             wr_en_q;
  logic [8:0]       wr_addr_q;
  logic [5:0]       wr_line_q;
  logic             frame_start_q;
  logic             line_done_q;
  logic             overrun_q;

  logic             hs_fall;
  logic             vs_fall;
  logic [LCW-1:0]   line_cnt_d;
  logic [PCW-1:0]   pix_cnt_d;
  logic [ACW-1:0]   act_cnt_d;
  logic [5:0]       wr_line_d;

  // Sync edge detection and saturating next-count values.
  always_comb begin
    hs_fall    = hs_prev_q & ~bus.HSYNC_src;
    vs_fall    = vs_prev_q & ~bus.VSYNC_src;
    line_cnt_d = (line_cnt_q == '1) ? line_cnt_q : line_cnt_q + LCW'(1);
    pix_cnt_d  = (pix_cnt_q  == '1) ? pix_cnt_q  : pix_cnt_q  + PCW'(1);
    act_cnt_d  = (act_cnt_q  == '1) ? act_cnt_q  : act_cnt_q  + ACW'(1);
    wr_line_d  = (wr_line_q == 6'(NUM_LINE_BUFFERS - 1)) ? 6'd0 : wr_line_q + 6'd1;
  end

  // Frame/line sequencing FSM; every output is registered here.
  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      hs_prev_q     <= 1'b1;
      vs_prev_q     <= 1'b1;
      line_cnt_q    <= '0;
      pix_cnt_q     <= '0;
      act_cnt_q     <= '0;
      addr_cnt_q    <= '0;
      armed_q       <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_line_q     <= '0;
      frame_start_q <= 1'b0;
      line_done_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      hs_prev_q     <= bus.HSYNC_src;
      vs_prev_q     <= bus.VSYNC_src;
      wr_en_q       <= 1'b0;
      frame_start_q <= 1'b0;
      line_done_q   <= 1'b0;

      // A vsync edge resynchronises from any state and wins over a coincident
      // hsync edge or line completion.
      if (vs_fall) begin
        state_q       <= VBLANK;
        line_cnt_q    <= '0;
        pix_cnt_q     <= '0;
        act_cnt_q     <= '0;
        armed_q       <= 1'b0;
        wr_line_q     <= '0;
        frame_start_q <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
          end

          VBLANK: begin
            if (hs_fall) begin
              line_cnt_q <= line_cnt_d;
              if (line_cnt_d == LCW'(V_START)) begin
                state_q   <= HWAIT;
                pix_cnt_q <= '0;
                armed_q   <= 1'b1;
              end
            end
          end

          // Pixels are only counted once this line's hsync has been seen
          // (armed); the first line is armed by the hsync that leaves VBLANK.
          HWAIT: begin
            if (hs_fall) begin
              pix_cnt_q <= '0;
              armed_q   <= 1'b1;
            end else if (armed_q && bus.pix_valid) begin
              pix_cnt_q <= pix_cnt_d;
              if (pix_cnt_d == PCW'(H_START)) begin
                state_q    <= ACTIVE;
                addr_cnt_q <= '0;
                wr_addr_q  <= '0;
              end
            end
          end

          ACTIVE: begin
            if (bus.pix_valid) begin
              wr_en_q    <= 1'b1;
              wr_addr_q  <= addr_cnt_q;
              addr_cnt_q <= addr_cnt_q + 9'd1;
              if (addr_cnt_q == 9'(H_ACTIVE - 1)) begin
                state_q <= LDONE;
              end
            end
          end

          LDONE: begin
            line_done_q <= 1'b1;
            act_cnt_q   <= act_cnt_d;
            wr_line_q   <= wr_line_d;
            pix_cnt_q   <= '0;
            armed_q     <= 1'b0;
            if (bus.rd_active && (wr_line_d == bus.rd_line)) begin
              overrun_q <= 1'b1;
            end
            if (act_cnt_d == ACW'(V_ACTIVE)) begin
              state_q <= IDLE;
            end else begin
              state_q <= HWAIT;
            end
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_line     = wr_line_q;
  assign bus.frame_start = frame_start_q;
  assign bus.line_done   = line_done_q;
  assign bus.overrun     = overrun_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_lbuf_wr_ctrl.sv
// tb/tb_lbuf_wr_ctrl.sv - scoreboard bench for the line-buffer write controller
module tb_lbuf_wr_ctrl;

  localparam int NLB = 40;
  localparam int HS  = 8;
  localparam int HA  = 208;
  localparam int VS  = 3;
  localparam int VA  = 45;

  logic PCLK = 1'b0;
  logic reset = 1'b1;

  lbuf_wr_ctrl_if bus ();

  lbuf_wr_ctrl #(
    .NUM_LINE_BUFFERS (NLB),
    .H_START          (HS),
    .H_ACTIVE         (HA),
    .V_START          (VS),
    .V_ACTIVE         (VA)
  ) dut (
    .PCLK  (PCLK),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_err = 0;
  int fs_cnt = 0;
  int ld_cnt = 0;
  int we_cnt = 0;
  int exp_line = 0;
  int gap = 4;

  logic [14:0] wr_q[$];
  logic [5:0]  ld_q[$];
  logic [14:0] exp_w;
  logic [5:0]  exp_l;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic strobe(input bit push, input int addr);
    bus.pix_valid = 1'b1;
    if (push) wr_q.push_back({6'(exp_line), 9'(addr)});
    step();
    bus.pix_valid = 1'b0;
    repeat (gap - 1) step();
  endtask

  task automatic hsync();
    bus.HSYNC_src = 1'b0;
    step();
    step();
    bus.HSYNC_src = 1'b1;
    step();
  endtask

  task automatic vsync_fall(input bit with_hs);
    int fs0;
    fs0 = fs_cnt;
    bus.VSYNC_src = 1'b0;
    if (with_hs) bus.HSYNC_src = 1'b0;
    step();
    step();
    bus.VSYNC_src = 1'b1;
    bus.HSYNC_src = 1'b1;
    step();
    exp_line = 0;
    chk("frame_start_once", fs_cnt - fs0, 1);
    chk("state_vblank_after_vsync", bus.state, 1);
  endtask

  task automatic frame_begin(input bit with_hs);
    vsync_fall(with_hs);
    for (int i = 0; i < VS - 1; i++) begin
      hsync();
      strobe(0, 0);
      strobe(0, 0);
      chk("blank_line_vblank", bus.state, 1);
    end
  endtask

  task automatic active_line(input bit vs_at_ldone);
    hsync();
    chk("hwait_after_hsync", bus.state, 2);
    for (int i = 0; i < HS; i++) strobe(0, 0);
    for (int i = 0; i < HA; i++) begin
      if (i == HA - 1 && !vs_at_ldone) ld_q.push_back(6'((exp_line + 1) % NLB));
      strobe(1, i);
    end
    if (vs_at_ldone) begin
      bus.VSYNC_src = 1'b0;
      step();
      step();
      bus.VSYNC_src = 1'b1;
      step();
      exp_line = 0;
    end else begin
      exp_line = (exp_line + 1) % NLB;
      strobe(0, 0);
      strobe(0, 0);
    end
  endtask

  // Scoreboard: pop expected writes and line completions as the DUT reports them.
  always @(negedge PCLK) begin
    if (bus.frame_start) fs_cnt++;
    if (bus.wr_en) begin
      we_cnt++;
      chk("wr_en_expected", wr_q.size() != 0, 1);
      if (wr_q.size() != 0) begin
        exp_w = wr_q.pop_front();
        chk("wr_line_addr", {bus.wr_line, bus.wr_addr}, exp_w);
      end
    end
    if (bus.line_done) begin
      ld_cnt++;
      chk("line_done_expected", ld_q.size() != 0, 1);
      if (ld_q.size() != 0) begin
        exp_l = ld_q.pop_front();
        chk("line_done_wr_line", bus.wr_line, exp_l);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ld0;
    int fs0;
    int we0;
    bus.HSYNC_src = 1'b1;
    bus.VSYNC_src = 1'b1;
    bus.pix_valid = 1'b0;
    bus.rd_line   = 6'd63;
    bus.rd_active = 1'b0;

    // Reset values
    step();
    step();
    chk("rst_state", bus.state, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_line", bus.wr_line, 0);
    chk("rst_frame_start", bus.frame_start, 0);
    chk("rst_line_done", bus.line_done, 0);
    chk("rst_overrun", bus.overrun, 0);
    reset = 1'b0;
    step();

    // Nominal frame, every 4th cycle a pixel; ring wraps 0..39, 0..4
    gap = 4;
    bus.rd_active = 1'b1;
    bus.rd_line   = 6'd63;
    frame_begin(1'b0);
    for (int l = 0; l < VA; l++) active_line(1'b0);
    step();
    step();
    chk("nom_state_idle", bus.state, 0);
    chk("nom_line_done_count", ld_cnt, VA);
    chk("nom_wr_en_count", we_cnt, VA * HA);
    chk("nom_wr_q_empty", wr_q.size(), 0);
    chk("nom_ld_q_empty", ld_q.size(), 0);
    chk("nom_wr_line_final", bus.wr_line, VA % NLB);
    chk("nom_no_overrun", bus.overrun, 0);
    hsync();
    strobe(0, 0);
    strobe(0, 0);
    chk("idle_ignores_hsync", bus.state, 0);

    // Overrun when the writer advances into the slot being read
    gap = 1;
    bus.rd_active = 1'b1;
    bus.rd_line   = 6'd7;
    frame_begin(1'b0);
    for (int l = 0; l < 8; l++) begin
      active_line(1'b0);
      chk("overrun_after_line", bus.overrun, (l >= 6) ? 1 : 0);
    end
    frame_begin(1'b0);
    active_line(1'b0);
    chk("overrun_held_next_frame", bus.overrun, 1);

    // Reset during ACTIVE aborts and waits for a fresh vsync
    gap = 2;
    bus.rd_active = 1'b0;
    frame_begin(1'b0);
    active_line(1'b0);
    hsync();
    for (int i = 0; i < HS; i++) strobe(0, 0);
    for (int i = 0; i < 10; i++) strobe(1, i);
    step();
    chk("pre_reset_active", bus.state, 3);
    reset = 1'b1;
    bus.pix_valid = 1'b1;
    step();
    bus.pix_valid = 1'b0;
    chk("midrst_state", bus.state, 0);
    chk("midrst_wr_en", bus.wr_en, 0);
    chk("midrst_wr_addr", bus.wr_addr, 0);
    chk("midrst_wr_line", bus.wr_line, 0);
    chk("midrst_frame_start", bus.frame_start, 0);
    chk("midrst_line_done", bus.line_done, 0);
    chk("midrst_overrun", bus.overrun, 0);
    step();
    reset = 1'b0;
    step();
    we0 = we_cnt;
    for (int h = 0; h < VS + 1; h++) begin
      hsync();
      for (int i = 0; i < HS + 4; i++) strobe(0, 0);
      chk("post_rst_idle", bus.state, 0);
    end
    chk("post_rst_no_write", we_cnt - we0, 0);
    frame_begin(1'b0);
    active_line(1'b0);
    chk("post_rst_line_ok", bus.wr_line, 1);

    // Vsync falling mid-line at wr_addr 200
    gap = 1;
    frame_begin(1'b0);
    active_line(1'b0);
    active_line(1'b0);
    hsync();
    for (int i = 0; i < HS; i++) strobe(0, 0);
    for (int i = 0; i <= 200; i++) strobe(1, i);
    ld0 = ld_cnt;
    fs0 = fs_cnt;
    bus.VSYNC_src = 1'b0;
    bus.pix_valid = 1'b1;
    step();
    step();
    bus.VSYNC_src = 1'b1;
    step();
    step();
    bus.pix_valid = 1'b0;
    step();
    exp_line = 0;
    chk("midvs_state_vblank", bus.state, 1);
    chk("midvs_wr_line", bus.wr_line, 0);
    chk("midvs_one_frame_start", fs_cnt - fs0, 1);
    chk("midvs_no_line_done", ld_cnt - ld0, 0);
    chk("midvs_wr_q_empty", wr_q.size(), 0);

    // Vsync coinciding with LDONE: no line_done, ring back to 0
    frame_begin(1'b0);
    active_line(1'b0);
    ld0 = ld_cnt;
    active_line(1'b1);
    step();
    chk("ldone_vs_no_line_done", ld_cnt - ld0, 0);
    chk("ldone_vs_wr_line", bus.wr_line, 0);
    chk("ldone_vs_state", bus.state, 1);

    // Hsync and vsync falling together count as vsync only
    frame_begin(1'b1);
    active_line(1'b0);
    active_line(1'b0);
    chk("same_edge_wr_line", bus.wr_line, 2);
    step();
    step();
    chk("end_wr_q_empty", wr_q.size(), 0);
    chk("end_ld_q_empty", ld_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lbuf_wr_ctrl.md
LBUF_WR_CTRL -- requirements
Module: lbuf_wr_ctrl

Interface
REQ-001 Parameter NUM_LINE_BUFFERS, default 40, number of line-buffer slots; wr_line wraps at this value.
REQ-002 Parameter H_START, default 64, pixel strobes after HSYNC_src falling edge before the first active pixel.
REQ-003 Parameter H_ACTIVE, default 384, active pixels written per line.
REQ-004 Parameter V_START, default 16, HSYNC_src falling edges after the VSYNC_src falling edge before the first active line.
REQ-005 Parameter V_ACTIVE, default 224, active lines written per frame.
REQ-006 PCLK  in  1  sole clock; all logic on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 HSYNC_src  in  1  source hsync, negative polarity, synchronous to PCLK.
REQ-009 VSYNC_src  in  1  source vsync, negative polarity, synchronous to PCLK.
REQ-010 pix_valid  in  1  one-cycle strobe marking one source pixel.
REQ-011 rd_line  in  6  line slot currently read by the output sync generator.
REQ-012 rd_active  in  1  high while the reader is locked and consuming slots.
REQ-013 wr_en  out  1  line-buffer write enable, one cycle per active pixel.
REQ-014 wr_addr  out  9  pixel address within the line, 0..H_ACTIVE-1.
REQ-015 wr_line  out  6  slot being written, 0..NUM_LINE_BUFFERS-1.
REQ-016 frame_start  out  1  one-cycle pulse on each accepted VSYNC_src falling edge.
REQ-017 line_done  out  1  one-cycle pulse after the last pixel of each active line.
REQ-018 overrun  out  1  sticky flag: writer advanced into the slot being read.
REQ-019 state  out  3  current FSM state encoding, for debug.

Function
REQ-020 Edges SHALL be detected against registered previous values of HSYNC_src and VSYNC_src; both previous registers reset to 1.
REQ-021 FSM states SHALL be IDLE=0, VBLANK=1, HWAIT=2, ACTIVE=3, LDONE=4.
REQ-022 IDLE: on a VSYNC_src falling edge -> VBLANK; clear the line counter; set wr_line=0; pulse frame_start the next cycle.
REQ-023 VBLANK: each HSYNC_src falling edge increments the line counter; when the edge making the count equal V_START arrives -> HWAIT with the pixel counter cleared.
REQ-024 HWAIT: each pix_valid increments the pixel counter; on the strobe making the count equal H_START -> ACTIVE with wr_addr=0; no write occurs on that strobe.
REQ-025 ACTIVE: each pix_valid SHALL assert wr_en for exactly one cycle, registered (one-cycle latency), with the current wr_addr; wr_addr then increments.
REQ-026 ACTIVE: the write with wr_addr=H_ACTIVE-1 -> LDONE; wr_en SHALL never assert outside ACTIVE.
REQ-027 LDONE (one cycle): pulse line_done; increment the active-line count; wr_line SHALL advance modulo NUM_LINE_BUFFERS (NUM_LINE_BUFFERS-1 -> 0).
REQ-028 LDONE: if the active-line count reaches V_ACTIVE -> IDLE; otherwise -> HWAIT with the pixel counter cleared on the next HSYNC_src falling edge.
REQ-029 HWAIT after the first active line SHALL ignore pix_valid until an HSYNC_src falling edge.
REQ-030 In LDONE, if rd_active=1 and the advanced wr_line equals rd_line, overrun SHALL set and hold until reset; writing continues.
REQ-031 A VSYNC_src falling edge in any state other than IDLE SHALL behave as in REQ-022 (resync), aborting any partial line without a line_done pulse.
REQ-032 A VSYNC_src falling edge coinciding with LDONE SHALL take priority: no line_done pulse, and wr_line=0.
REQ-033 HSYNC_src and VSYNC_src falling in the same cycle SHALL count as a vsync only; the line counter stays 0.
REQ-034 Pixel and line counters SHALL be wide enough for their parameters and saturate rather than wrap.

Reset
REQ-035 While reset=1: state=IDLE, wr_en=0, wr_addr=0, wr_line=0, frame_start=0, line_done=0, overrun=0, all counters=0.
REQ-036 Reset asserted mid-line SHALL abort immediately; after release, no write occurs until a fresh VSYNC_src falling edge.

Verification
REQ-037 Nominal frame, pix_valid every 4th cycle -> 224 line_done pulses, each preceded by exactly 384 wr_en pulses with wr_addr 0..383, and the first write on the 65th strobe after the 16th hsync.
REQ-038 Run 45 active lines -> wr_line sequence 0..39, 0..4; no overrun while rd_line is kept distinct.
REQ-039 rd_active=1, rd_line=7, writer completes line 6 -> overrun=1 the cycle after LDONE and held across the next frame.
REQ-040 VSYNC_src falls at wr_addr=200 -> wr_en stops, no line_done, wr_line=0, state=VBLANK, one frame_start pulse.
REQ-041 HSYNC_src and VSYNC_src fall in the same cycle -> VBLANK with line count 0; the first active line starts after 16 further hsyncs.
REQ-042 reset pulsed during ACTIVE -> all outputs at reset values; state remains IDLE through hsyncs until a VSYNC_src falling edge.
